// File: rtl/key_cmd_arbiter.sv
// Captures debounced key pulses as pending flags and issues them one at a time
// as commands over valid/ready, round-robin, with a minimum gap between commands.
module key_cmd_arbiter #(
   parameter int          N_KEY   = 4,
   parameter logic [15:0] GAP_CYC = 16'd5000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_KEY-1:0] key_pulse,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic [1:0]       cmd_id,
   output logic [N_KEY-1:0] pending,
   output logic [N_KEY-1:0] ovf,
   input  logic             ovf_clr
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [N_KEY-1:0] pend_q, pend_d;
   logic [N_KEY-1:0] ovf_q, ovf_d;
   logic             valid_q, valid_d;
   logic [1:0]       id_q, id_d;
   logic [1:0]       rr_q, rr_d;
   logic [15:0]      gap_q, gap_d;

   logic             accept;
   logic [N_KEY-1:0] clr_vec;
   logic             grant_found;
   logic [1:0]       grant_id;

   assign accept = valid_q & cmd_ready;

   // A press landing on its own acceptance cycle survives: set wins over clear.
   always_comb begin
      clr_vec = '0;
      if (accept) clr_vec[id_q] = 1'b1;
      pend_d = (pend_q & ~clr_vec) | key_pulse;
      ovf_d  = (ovf_clr ? '0 : ovf_q) | (key_pulse & pend_q & ~clr_vec);
   end

   always_comb begin
      logic [1:0] idx;
      grant_found = 1'b0;
      grant_id    = rr_q;
      idx         = rr_q;
      for (int i = 0; i < N_KEY; i++) begin
         idx = rr_q + 2'(i);
         if (!grant_found && pend_q[idx]) begin
            grant_found = 1'b1;
            grant_id    = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      id_d    = id_q;
      rr_d    = rr_q;
      gap_d   = gap_q;
      case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               id_d    = grant_id;
               valid_d = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (accept) begin
               valid_d = 1'b0;
               rr_d    = id_q + 2'd1;
               if (GAP_CYC == 16'd0) begin
                  state_d = S_IDLE;
               end else begin
                  gap_d   = GAP_CYC - 16'd1;
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (gap_q == 16'd0) state_d = S_IDLE;
            else                gap_d   = gap_q - 16'd1;
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pend_q  <= '0;
         ovf_q   <= '0;
         valid_q <= 1'b0;
         id_q    <= 2'd0;
         rr_q    <= 2'd0;
         gap_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
         id_q    <= id_d;
         rr_q    <= rr_d;
         gap_q   <= gap_d;
      end
   end

   assign cmd_valid = valid_q;
   assign cmd_id    = id_q;
   assign pending   = pend_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_key_cmd_arbiter.sv
// Directed bench: a GAP_CYC=4 instance driven from a vector table, and a
// GAP_CYC=0 instance exercised by hand-written handshake/overflow sequences.
module tb_key_cmd_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key_pulse;
   logic       cmd_ready;
   logic       ovf_clr;

   logic       g4_valid, g0_valid;
   logic [1:0] g4_id, g0_id;
   logic [3:0] g4_pend, g0_pend, g4_ovf, g0_ovf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   key_cmd_arbiter #(.N_KEY(4), .GAP_CYC(16'd4)) u_g4 (
      .clk(clk), .rst(rst), .key_pulse(key_pulse), .cmd_valid(g4_valid),
      .cmd_ready(cmd_ready), .cmd_id(g4_id), .pending(g4_pend), .ovf(g4_ovf),
      .ovf_clr(ovf_clr));

   key_cmd_arbiter #(.N_KEY(4), .GAP_CYC(16'd0)) u_g0 (
      .clk(clk), .rst(rst), .key_pulse(key_pulse), .cmd_valid(g0_valid),
      .cmd_ready(cmd_ready), .cmd_id(g0_id), .pending(g0_pend), .ovf(g0_ovf),
      .ovf_clr(ovf_clr));

   typedef struct {
      logic       rst;
      logic [3:0] key;
      logic       rdy;
      logic       clr;
      logic       ev;
      logic [1:0] eid;
      logic [3:0] ep;
      logic [3:0] eo;
   } vec_t;

   vec_t vecs [19];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; key_pulse = 4'b0; cmd_ready = 1'b0; ovf_clr = 1'b0;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; key_pulse = 4'b0; cmd_ready = 1'b0; ovf_clr = 1'b0;

      //            rst   key      rdy   clr   ev    eid    ep       eo
      vecs[0]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
      vecs[1]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
      vecs[2]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
      vecs[3]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
      vecs[4]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0100, 4'b0000};
      vecs[5]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000};
      vecs[6]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000};
      vecs[7]  = '{1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b1000, 4'b0000};
      vecs[8]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b1000, 4'b0000};
      vecs[9]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b1000, 4'b0000};
      vecs[10] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b1000, 4'b0000};
      vecs[11] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 4'b0000};
      vecs[12] = '{1'b0, 4'b1001, 1'b1, 1'b0, 1'b0, 2'd3, 4'b1001, 4'b0000};
      vecs[13] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b1001, 4'b0000};
      vecs[14] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b1001, 4'b0000};
      vecs[15] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b1001, 4'b0000};
      vecs[16] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b1001, 4'b0000};
      vecs[17] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1001, 4'b0000};
      vecs[18] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1001, 4'b0000};

      // Table: reset, single-key latency and gap, capture during gap, set-wins, wrap.
      for (int k = 0; k < 19; k++) begin
         rst = vecs[k].rst; key_pulse = vecs[k].key;
         cmd_ready = vecs[k].rdy; ovf_clr = vecs[k].clr;
         step();
         chk($sformatf("v%0d valid", k), {3'b0, g4_valid}, {3'b0, vecs[k].ev});
         chk($sformatf("v%0d id", k),    {2'b0, g4_id},    {2'b0, vecs[k].eid});
         chk($sformatf("v%0d pending", k), g4_pend, vecs[k].ep);
         chk($sformatf("v%0d ovf", k),   g4_ovf,   vecs[k].eo);
      end

      // Simultaneous presses, zero gap: grants 0,1,3 two cycles apart.
      do_reset();
      key_pulse = 4'b1011; cmd_ready = 1'b1;
      step(); key_pulse = 4'b0;
      chk("sim pend0", g0_pend, 4'b1011);
      chk("sim valid0", {3'b0, g0_valid}, 4'd0);
      step();
      chk("sim valid1", {3'b0, g0_valid}, 4'd1);
      chk("sim id1", {2'b0, g0_id}, 4'd0);
      step();
      chk("sim gap1", {3'b0, g0_valid}, 4'd0);
      chk("sim pend1", g0_pend, 4'b1010);
      step();
      chk("sim id2", {2'b0, g0_id}, 4'd1);
      chk("sim valid2", {3'b0, g0_valid}, 4'd1);
      step();
      chk("sim pend2", g0_pend, 4'b1000);
      step();
      chk("sim id3", {2'b0, g0_id}, 4'd3);
      chk("sim valid3", {3'b0, g0_valid}, 4'd1);
      step();
      chk("sim pend_end", g0_pend, 4'b0000);
      chk("sim valid_end", {3'b0, g0_valid}, 4'd0);

      // Backpressure: id 1 held while a key 0 press arrives, then key 0 follows.
      do_reset();
      key_pulse = 4'b0010;
      step(); key_pulse = 4'b0;
      step();
      chk("bp valid", {3'b0, g0_valid}, 4'd1);
      chk("bp id", {2'b0, g0_id}, 4'd1);
      key_pulse = 4'b0001;
      step(); key_pulse = 4'b0;
      chk("bp pend", g0_pend, 4'b0011);
      for (int c = 0; c < 9; c++) begin
         step();
         chk($sformatf("bp hold%0d valid", c), {3'b0, g0_valid}, 4'd1);
         chk($sformatf("bp hold%0d id", c), {2'b0, g0_id}, 4'd1);
      end
      cmd_ready = 1'b1;
      step();
      chk("bp acc valid", {3'b0, g0_valid}, 4'd0);
      chk("bp acc pend", g0_pend, 4'b0001);
      step();
      chk("bp next valid", {3'b0, g0_valid}, 4'd1);
      chk("bp next id", {2'b0, g0_id}, 4'd0);

      // Overflow: sticky set, set beats clear, clear alone, press on acceptance.
      do_reset();
      key_pulse = 4'b0100;
      step();
      chk("ovf first", g0_ovf, 4'b0000);
      chk("ovf pend", g0_pend, 4'b0100);
      step();
      chk("ovf set", g0_ovf, 4'b0100);
      ovf_clr = 1'b1;
      step();
      chk("ovf set_vs_clr", g0_ovf, 4'b0100);
      key_pulse = 4'b0;
      step();
      chk("ovf clr", g0_ovf, 4'b0000);
      chk("ovf valid", {3'b0, g0_valid}, 4'd1);
      ovf_clr = 1'b0; key_pulse = 4'b0100; cmd_ready = 1'b1;
      step();
      key_pulse = 4'b0;
      chk("acc press pend", g0_pend, 4'b0100);
      chk("acc press ovf", g0_ovf, 4'b0000);
      chk("acc press valid", {3'b0, g0_valid}, 4'd0);
      step();
      chk("acc press regrant", {3'b0, g0_valid}, 4'd1);
      chk("acc press id", {2'b0, g0_id}, 4'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
